// File: rtl/led_hex_out_pkg.sv
// Shared definitions for the LED / 7-segment output port.
// Register map, CTRL bit positions and default timing.
package led_hex_out_pkg;

    localparam logic [1:0] ADDR_HEX    = 2'd0;
    localparam logic [1:0] ADDR_LED    = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_BLANK_LSB = 0;
    localparam int CTRL_BLINK_LSB = 8;
    localparam int CTRL_LED_BLINK = 16;

    localparam int TICK_DIV_DEFAULT    = 1250000;
    localparam int BLINK_TICKS_DEFAULT = 20;
    localparam int NUM_DIGITS          = 6;

    typedef struct packed {
        logic       led_blink;
        logic [5:0] blink;
        logic [5:0] blank;
    } ctrl_t;

    // Power-up state blanks every digit until software configures CTRL.
    localparam ctrl_t CTRL_RESET = '{
        led_blink: 1'b0,
        blink:     6'h00,
        blank:     6'h3F
    };

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_LED_BLINK]       = c.led_blink;
        w[CTRL_BLINK_LSB +: 6]  = c.blink;
        w[CTRL_BLANK_LSB +: 6]  = c.blank;
        return w;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational; one instance per digit.
module seg7_dec (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Lookup table covering all sixteen hex digits
    always_comb begin
        seg = 7'h7F;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/led_hex_out.sv
// Memory-mapped HEX0..HEX5 / LEDR output port with shadow registers.
// Shadow values commit to the display only on a prescaler tick.
module led_hex_out
    import led_hex_out_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int BLINK_TICKS = BLINK_TICKS_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic        RE,
    input  logic [1:0]  ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5,
    output logic [9:0]  LEDR
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          pending_q, pending_d;
    logic [23:0]   s_hex_q, s_hex_d, a_hex_q, a_hex_d;
    logic [9:0]    s_led_q, s_led_d, a_led_q, a_led_d;
    ctrl_t         s_ctrl_q, s_ctrl_d, a_ctrl_q, a_ctrl_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [NUM_DIGITS-1:0][7:0] hex_q, hex_d;
    logic [9:0]    ledr_q, ledr_d;
    logic [NUM_DIGITS-1:0][6:0] seg;
    logic          tick;
    logic          wr_hex, wr_led, wr_ctrl;
    logic          unused_wdata;

    assign unused_wdata = ^WDATA[31:24];

    // Prescaler: update tick and blink phase generation
    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick) begin
            if (bcnt_q == BCNT_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // Register file: CPU writes to shadows, tick commits, reads
    always_comb begin
        wr_hex  = WE && (ADDR == ADDR_HEX);
        wr_led  = WE && (ADDR == ADDR_LED);
        wr_ctrl = WE && (ADDR == ADDR_CTRL);

        s_hex_d  = wr_hex ? WDATA[23:0] : s_hex_q;
        s_led_d  = wr_led ? WDATA[9:0]  : s_led_q;
        s_ctrl_d = s_ctrl_q;
        if (wr_ctrl) begin
            s_ctrl_d.blank     = WDATA[CTRL_BLANK_LSB +: 6];
            s_ctrl_d.blink     = WDATA[CTRL_BLINK_LSB +: 6];
            s_ctrl_d.led_blink = WDATA[CTRL_LED_BLINK];
        end

        // Commit takes the pre-write shadow; a same-cycle write waits a tick
        a_hex_d  = tick ? s_hex_q  : a_hex_q;
        a_led_d  = tick ? s_led_q  : a_led_q;
        a_ctrl_d = tick ? s_ctrl_q : a_ctrl_q;

        pending_d = pending_q;
        if (tick)
            pending_d = 1'b0;
        if (wr_hex || wr_led || wr_ctrl)
            pending_d = 1'b1;

        rdata_d = rdata_q;
        if (RE) begin
            unique case (ADDR)
                ADDR_HEX:    rdata_d = {8'h00, s_hex_q};
                ADDR_LED:    rdata_d = {22'h0, s_led_q};
                ADDR_CTRL:   rdata_d = ctrl_to_word(s_ctrl_q);
                ADDR_STATUS: rdata_d = {30'h0, phase_q, pending_q};
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_dec u_seg (
            .nib (a_hex_q[4*g +: 4]),
            .seg (seg[g])
        );
    end

    // Output stage: blanking, blinking and LED gating
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (a_ctrl_q.blank[i] || (a_ctrl_q.blink[i] && !phase_q))
                hex_d[i] = 8'hFF;
            else
                hex_d[i] = {1'b1, seg[i]};
        end
        ledr_d = (a_ctrl_q.led_blink && !phase_q) ? 10'h000 : a_led_q;
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q     <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b1;
            pending_q <= 1'b0;
            s_hex_q   <= '0;
            a_hex_q   <= '0;
            s_led_q   <= '0;
            a_led_q   <= '0;
            s_ctrl_q  <= CTRL_RESET;
            a_ctrl_q  <= CTRL_RESET;
            rdata_q   <= '0;
            hex_q     <= {NUM_DIGITS{8'hFF}};
            ledr_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            s_hex_q   <= s_hex_d;
            a_hex_q   <= a_hex_d;
            s_led_q   <= s_led_d;
            a_led_q   <= a_led_d;
            s_ctrl_q  <= s_ctrl_d;
            a_ctrl_q  <= a_ctrl_d;
            rdata_q   <= rdata_d;
            hex_q     <= hex_d;
            ledr_q    <= ledr_d;
        end
    end

    assign RDATA = rdata_q;
    assign HEX0  = hex_q[0];
    assign HEX1  = hex_q[1];
    assign HEX2  = hex_q[2];
    assign HEX3  = hex_q[3];
    assign HEX4  = hex_q[4];
    assign HEX5  = hex_q[5];
    assign LEDR  = ledr_q;

endmodule
